// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin write-port arbiter with host burst lock for the MIPS register file.
// Optional macro RF_ARB_ZERO_GUARD_EN suppresses rf_we for accepted writes to register 0.
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req_valid,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [AW-1:0] req_addr2,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  input  logic [DW-1:0] req_data2,
  input  logic          host_lock,
  output logic [2:0]    req_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  output logic          locked,
  output logic [1:0]    last_grant
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t r_state, w_next;
  logic [1:0] r_last, w_p0, w_p1, w_p2, w_win;
  logic w_acc, w_we;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data, r_data;
  logic r_we;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
  // A locked host that drops valid releases the port in that same cycle.
  always_comb begin
    w_p0 = nxt(r_last);
    w_p1 = nxt(w_p0);
    w_p2 = nxt(w_p1);
    locked = (r_state == LOCKED) && req_valid[2];
    w_win = locked ? 2'd2 : req_valid[w_p0] ? w_p0 : req_valid[w_p1] ? w_p1 : w_p2;
    w_acc = !rst && |req_valid;
    req_ready = w_acc ? (3'b001 << w_win) : 3'b000;
    w_next = (req_ready[2] && host_lock) ? LOCKED : ARB;
    w_addr = (w_win == 2'd0) ? req_addr0 : (w_win == 2'd1) ? req_addr1 : req_addr2;
    w_data = (w_win == 2'd0) ? req_data0 : (w_win == 2'd1) ? req_data1 : req_data2;
  end
`ifdef RF_ARB_ZERO_GUARD_EN
  assign w_we = w_acc && |w_addr;
`else
  assign w_we = w_acc;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ARB;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_last <= 2'd2;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_we;
      if (w_acc) begin
        r_last <= w_win;
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  assign rf_we      = r_we;
  assign rf_addr    = r_addr;
  assign rf_wdata   = r_data;
  assign last_grant = r_last;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and random checks of regfile_wr_arbiter against a behavioural model.
module tb_regfile_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] v_valid = 3'b000;
  logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0;
  logic v_lock = 1'b0;
  logic [2:0] req_ready;
  logic rf_we, locked;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [1:0] last_grant;
  int n_chk = 0, n_fail = 0;
  bit m_locked, e_we;
  int m_ptr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit pend[3];
  int w;

  regfile_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(v_valid),
    .req_addr0(a0), .req_addr1(a1), .req_addr2(a2),
    .req_data0(d0), .req_data1(d1), .req_data2(d2),
    .host_lock(v_lock), .req_ready(req_ready), .rf_we(rf_we),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .locked(locked), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_ptr = 2;
    e_we = 0;
    e_addr = '0;
    e_data = '0;
  endtask

  // Host keeps the port while locked and valid; otherwise first valid requester after the last winner.
  function automatic int model_win();
    if (m_locked && v_valid[2]) return 2;
    for (int k = 1; k <= 3; k++)
      if (v_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  task automatic step(output int win);
    logic [AW-1:0] ad;
    logic [DW-1:0] da;
    #1;
    win = model_win();
    chk("req_ready", req_ready, (win < 0) ? 64'd0 : (64'd1 << win));
    chk("locked", locked, m_locked && v_valid[2]);
    @(posedge clk);
    if (win >= 0) begin
      ad = (win == 0) ? a0 : (win == 1) ? a1 : a2;
      da = (win == 0) ? d0 : (win == 1) ? d1 : d2;
      m_ptr = win;
      m_locked = (win == 2) && v_lock;
      e_addr = ad;
      e_data = da;
      e_we = 1;
`ifdef RF_ARB_ZERO_GUARD_EN
      if (ad == 0) e_we = 0;
`endif
    end else begin
      m_locked = 0;
      e_we = 0;
    end
    @(negedge clk);
    chk("rf_we", rf_we, e_we);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_wdata", rf_wdata, e_data);
    chk("last_grant", last_grant, m_ptr);
  endtask

  initial begin
    v_valid = 3'b111;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_wdata, 0);
    chk("rst_locked", locked, 0);
    chk("rst_last", last_grant, 2);
    rst = 0;
    model_reset();
    a0 = 1; a1 = 2; a2 = 3;
    d0 = 32'h11; d1 = 32'h22; d2 = 32'h33;
    for (int i = 0; i < 3; i++) begin
      step(w);
      chk("rr_grant", w, i);
      chk("rr_addr", rf_addr, i + 1);
    end
    v_valid = 3'b000;
    step(w);
    chk("idle_we", rf_we, 0);
    chk("idle_hold", rf_addr, 3);
    v_valid = 3'b001; a0 = 5;
    step(w);
    chk("pre_burst", w, 0);
    v_valid = 3'b101; v_lock = 1;
    for (int i = 0; i < 3; i++) begin
      a2 = AW'(8 + i);
      step(w);
      chk("burst_grant", w, 2);
      chk("burst_locked", locked, 1);
      chk("burst_alu_ready", req_ready[0], 0);
    end
    a2 = 11; v_lock = 0;
    step(w);
    chk("release_grant", w, 2);
    v_valid = 3'b001;
    step(w);
    chk("alu_after_release", w, 0);
    v_valid = 3'b100; v_lock = 1; a2 = 12;
    step(w);
    v_valid = 3'b010; a1 = 7;
    #1;
    chk("drop_locked", locked, 0);
    step(w);
    chk("drop_load_grant", w, 1);
    v_valid = 3'b100; a2 = 13; d2 = 32'h1234;
    step(w);
    chk("mid_locked", locked, 1);
    chk("mid_we", rf_we, 1);
    rst = 1;
    #1;
    chk("async_we", rf_we, 0);
    chk("async_addr", rf_addr, 0);
    chk("async_data", rf_wdata, 0);
    chk("async_locked", locked, 0);
    chk("async_ready", req_ready, 0);
    chk("async_last", last_grant, 2);
    model_reset();
    @(negedge clk);
    rst = 0;
    v_valid = 3'b111; v_lock = 0;
    step(w);
    chk("post_rst_grant", w, 0);
    v_valid = 3'b010; a1 = 0; d1 = 32'hDEADBEEF;
    step(w);
`ifdef RF_ARB_ZERO_GUARD_EN
    chk("zero_we", rf_we, 0);
`else
    chk("zero_we", rf_we, 1);
    chk("zero_addr", rf_addr, 0);
    chk("zero_data", rf_wdata, 32'hDEADBEEF);
`endif
    chk("zero_last", last_grant, 1);
    pend = '{0, 0, 0};
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1;
          if (i == 0) begin a0 = AW'($urandom); d0 = $urandom; end
          if (i == 1) begin a1 = AW'($urandom); d1 = $urandom; end
          if (i == 2) begin a2 = AW'($urandom); d2 = $urandom; v_lock = 1'($urandom); end
        end
      v_valid = {pend[2], pend[1], pend[0]};
      step(w);
      if (w >= 0) pend[w] = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
